// File: rtl/fpgaudio_pkg.sv
// Shared FSM state codes and note constants for the fpgaudio control units
// (recording, playback, compare).
package fpgaudio_pkg;

    typedef enum logic [3:0] {
        st_inicial       = 4'd0,
        st_inicializa    = 4'd1,
        st_espera_nota   = 4'd2,
        st_registra_nota = 4'd3,
        st_mede_duracao  = 4'd4,
        st_grava         = 4'd5,
        st_finalizado    = 4'd6,
        st_cheio         = 4'd7,
        st_grava_pausa   = 4'd8
    } estado_t;

    // Note code 0 marks a rest, never a real key.
    localparam int NOTA_PAUSA = 0;

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with clear, load-to-one and enable; used for the
// note duration and rest length measured in ticks.
module contador_saturado #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load1,
    input  logic         enable,
    output logic [W-1:0] valor
);

    localparam logic [W-1:0] MAXIMO = '1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            valor <= '0;
        end else if (clear) begin
            valor <= '0;
        end else if (load1) begin
            valor <= W'(1);
        end else if (enable && (valor != MAXIMO)) begin
            valor <= valor + W'(1);
        end
    end

endmodule

// File: rtl/modo_gravacao_unidade_controle.sv
// Recording-mode control unit: measures held keys in ticks and writes
// {note, duration} words to melody memory. Macro GRAVA_PAUSA_EN adds rest words.
//
//   state            | meaning
//   inicial       0  | idle after reset
//   inicializa    1  | clear address, word count and counters
//   espera_nota   2  | waiting for a key (rest length counted here)
//   registra_nota 3  | latch key code, duration starts at 1
//   mede_duracao  4  | key held, count ticks
//   grava         5  | write {note, duration}
//   finalizado    6  | recording ended by finalizar
//   cheio         7  | recording ended by full memory
//   grava_pausa   8  | write {rest, rest length} before the next note
module modo_gravacao_unidade_controle
    import fpgaudio_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int NOTA_W = 4,
    parameter int DUR_W  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic                    finalizar,
    input  logic                    nota_feita,
    input  logic [NOTA_W-1:0]       nota,
    input  logic                    tick,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [NOTA_W+DUR_W-1:0] mem_dado,
    output logic [ADDR_W:0]         num_notas,
    output logic                    gravando,
    output logic                    toca,
    output logic                    fim_gravacao,
    output logic                    memoria_cheia,
    output logic [3:0]              db_estado
);

    estado_t estado, prox;

    logic [NOTA_W-1:0] nota_reg;
    logic [DUR_W-1:0]  dur_cnt;
    logic              tecla;
    logic              addr_max;
    logic              escreve;

    assign tecla    = nota_feita && (nota != NOTA_W'(NOTA_PAUSA));
    assign addr_max = (mem_addr == {ADDR_W{1'b1}});
    assign escreve  = (estado == st_grava) || (estado == st_grava_pausa);

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= st_inicial;
        end else begin
            estado <= prox;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            nota_reg <= '0;
        end else if (estado == st_registra_nota) begin
            nota_reg <= nota;
        end
    end

    // Address stops at the last word so it never wraps; the count may reach 2^ADDR_W.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_addr  <= '0;
            num_notas <= '0;
        end else if (estado == st_inicializa) begin
            mem_addr  <= '0;
            num_notas <= '0;
        end else if (escreve) begin
            num_notas <= num_notas + 1'b1;
            if (!addr_max) begin
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

    // A tick in the release cycle is not counted.
    contador_saturado #(.W(DUR_W)) u_dur (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado == st_inicializa),
        .load1  (estado == st_registra_nota),
        .enable ((estado == st_mede_duracao) && tick && nota_feita),
        .valor  (dur_cnt)
    );

`ifdef GRAVA_PAUSA_EN
    logic [DUR_W-1:0] pausa_cnt;

    // No leading rest (count must be nonzero) and a pending rest is dropped on finalizar.
    contador_saturado #(.W(DUR_W)) u_pausa (
        .clock  (clock),
        .reset  (reset),
        .clear  ((estado == st_inicializa) || escreve ||
                 ((estado == st_espera_nota) && finalizar)),
        .load1  (1'b0),
        .enable ((estado == st_espera_nota) && tick && (num_notas != '0) &&
                 !finalizar && !tecla),
        .valor  (pausa_cnt)
    );
`endif

    always_comb begin
        prox          = estado;
        mem_we        = 1'b0;
        mem_dado      = '0;
        gravando      = 1'b0;
        toca          = 1'b0;
        fim_gravacao  = 1'b0;
        memoria_cheia = 1'b0;
        unique case (estado)
            st_inicial: begin
                if (iniciar) prox = st_inicializa;
            end
            st_inicializa: begin
                prox = st_espera_nota;
            end
            st_espera_nota: begin
                gravando = 1'b1;
                if (finalizar) begin
                    prox = st_finalizado;
                end else if (tecla) begin
`ifdef GRAVA_PAUSA_EN
                    prox = (pausa_cnt != '0) ? st_grava_pausa : st_registra_nota;
`else
                    prox = st_registra_nota;
`endif
                end
            end
            st_registra_nota: begin
                gravando = 1'b1;
                prox     = st_mede_duracao;
            end
            st_mede_duracao: begin
                gravando = 1'b1;
                toca     = 1'b1;
                if (!nota_feita) prox = st_grava;
            end
            st_grava: begin
                gravando = 1'b1;
                mem_we   = 1'b1;
                mem_dado = {nota_reg, dur_cnt};
                prox     = addr_max ? st_cheio : st_espera_nota;
            end
`ifdef GRAVA_PAUSA_EN
            st_grava_pausa: begin
                gravando = 1'b1;
                mem_we   = 1'b1;
                mem_dado = {NOTA_W'(NOTA_PAUSA), pausa_cnt};
                prox     = addr_max ? st_cheio : st_registra_nota;
            end
`endif
            st_finalizado: begin
                fim_gravacao = 1'b1;
                if (iniciar) prox = st_inicializa;
            end
            st_cheio: begin
                fim_gravacao  = 1'b1;
                memoria_cheia = 1'b1;
                if (iniciar) prox = st_inicializa;
            end
            default: begin
                prox = st_inicial;
            end
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_modo_gravacao_unidade_controle.sv
// Directed bench for the recording control unit: a default instance plus an
// ADDR_W=2 instance sharing the same stimulus for the full-memory case.
module tb_modo_gravacao_unidade_controle;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       finalizar;
    logic       nota_feita;
    logic [3:0] nota;
    logic       tick;

    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_dado;
    logic [6:0] num_notas;
    logic       gravando, toca, fim_gravacao, memoria_cheia;
    logic [3:0] db_estado;

    logic       p_mem_we;
    logic [1:0] p_mem_addr;
    logic [7:0] p_mem_dado;
    logic [2:0] p_num_notas;
    logic       p_gravando, p_toca, p_fim_gravacao, p_memoria_cheia;
    logic [3:0] p_db_estado;

    int checks = 0;
    int errors = 0;

    modo_gravacao_unidade_controle u_dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .finalizar     (finalizar),
        .nota_feita    (nota_feita),
        .nota          (nota),
        .tick          (tick),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_dado      (mem_dado),
        .num_notas     (num_notas),
        .gravando      (gravando),
        .toca          (toca),
        .fim_gravacao  (fim_gravacao),
        .memoria_cheia (memoria_cheia),
        .db_estado     (db_estado)
    );

    modo_gravacao_unidade_controle #(.ADDR_W(2)) u_pequeno (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .finalizar     (finalizar),
        .nota_feita    (nota_feita),
        .nota          (nota),
        .tick          (tick),
        .mem_we        (p_mem_we),
        .mem_addr      (p_mem_addr),
        .mem_dado      (p_mem_dado),
        .num_notas     (p_num_notas),
        .gravando      (p_gravando),
        .toca          (p_toca),
        .fim_gravacao  (p_fim_gravacao),
        .memoria_cheia (p_memoria_cheia),
        .db_estado     (p_db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Press from espera_nota, hold for n ticks, release; returns in the grava state.
    task automatic press(input logic [3:0] n, input int ticks);
        nota_feita = 1'b1;
        nota       = n;
        cyc();
        cyc();
        for (int i = 0; i < ticks; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
        nota_feita = 1'b0;
        nota       = 4'd0;
        cyc();
    endtask

    task automatic restart();
        finalizar = 1'b1;
        cyc();
        finalizar = 1'b0;
        iniciar   = 1'b1;
        cyc();
        iniciar   = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0; iniciar = 1'b0; finalizar = 1'b0;
        nota_feita = 1'b0; nota = 4'd0; tick = 1'b0;
        cyc();
        cyc();
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        checks++;
        if ({mem_we, gravando, toca, fim_gravacao, memoria_cheia} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {mem_we, gravando, toca, fim_gravacao, memoria_cheia});
        end
        checks++;
        if ({mem_dado, mem_addr, num_notas} !== 21'd0) begin
            errors++; $display("FAIL reset_dados: got dado=%0h addr=%0d num=%0d expected 0", mem_dado, mem_addr, num_notas);
        end
        reset   = 1'b1;
        iniciar = 1'b1;
        cyc();
        checks++;
        if (db_estado !== 4'd1 || gravando !== 1'b0) begin
            errors++; $display("FAIL inicializa: got estado=%0d gravando=%b expected 1/0", db_estado, gravando);
        end
        iniciar = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd2 || gravando !== 1'b1 || toca !== 1'b0 || mem_we !== 1'b0 || fim_gravacao !== 1'b0) begin
            errors++; $display("FAIL espera: got estado=%0d grav=%b toca=%b we=%b fim=%b expected 2/1/0/0/0",
                               db_estado, gravando, toca, mem_we, fim_gravacao);
        end
    endtask

    task automatic test_nota();
        nota_feita = 1'b1;
        nota       = 4'd0;
        cyc();
        checks++;
        if (db_estado !== 4'd2) begin errors++; $display("FAIL nota_zero: got estado=%0d expected 2", db_estado); end
        nota_feita = 1'b0;
        nota_feita = 1'b1;
        nota       = 4'd5;
        cyc();
        cyc();
        checks++;
        if (db_estado !== 4'd4 || toca !== 1'b1) begin
            errors++; $display("FAIL mede: got estado=%0d toca=%b expected 4/1", db_estado, toca);
        end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        nota_feita = 1'b0;
        nota       = 4'd0;
        cyc();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_dado !== 8'h54) begin
            errors++; $display("FAIL grava_54: got we=%b addr=%0d dado=%0h expected 1/0/54", mem_we, mem_addr, mem_dado);
        end
        cyc();
        checks++;
        if (mem_we !== 1'b0 || num_notas !== 7'd1 || mem_addr !== 6'd1 || db_estado !== 4'd2) begin
            errors++; $display("FAIL apos_grava: got we=%b num=%0d addr=%0d estado=%0d expected 0/1/1/2",
                               mem_we, num_notas, mem_addr, db_estado);
        end
    endtask

    task automatic test_saturacao();
        press(4'd9, 20);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_dado !== 8'h9F) begin
            errors++; $display("FAIL saturacao: got we=%b addr=%0d dado=%0h expected 1/1/9f", mem_we, mem_addr, mem_dado);
        end
        cyc();
        checks++;
        if (num_notas !== 7'd2) begin errors++; $display("FAIL sat_num: got %0d expected 2", num_notas); end
    endtask

    task automatic test_pausa();
        finalizar = 1'b1;
        cyc();
        checks++;
        if (db_estado !== 4'd6 || fim_gravacao !== 1'b1 || memoria_cheia !== 1'b0 || gravando !== 1'b0) begin
            errors++; $display("FAIL finalizado: got estado=%0d fim=%b cheia=%b grav=%b expected 6/1/0/0",
                               db_estado, fim_gravacao, memoria_cheia, gravando);
        end
        finalizar = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd6 || num_notas !== 7'd2 || mem_addr !== 6'd2) begin
            errors++; $display("FAIL finalizado_hold: got estado=%0d num=%0d addr=%0d expected 6/2/2", db_estado, num_notas, mem_addr);
        end
        iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd2 || num_notas !== 7'd0 || mem_addr !== 6'd0) begin
            errors++; $display("FAIL reinicio: got estado=%0d num=%0d addr=%0d expected 2/0/0", db_estado, num_notas, mem_addr);
        end
        press(4'd3, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_dado !== 8'h31) begin
            errors++; $display("FAIL pausa_w0: got we=%b addr=%0d dado=%0h expected 1/0/31", mem_we, mem_addr, mem_dado);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        nota_feita = 1'b1;
        nota       = 4'd7;
        cyc();
`ifdef GRAVA_PAUSA_EN
        checks++;
        if (db_estado !== 4'd8 || mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_dado !== 8'h02) begin
            errors++; $display("FAIL pausa_w1: got estado=%0d we=%b addr=%0d dado=%0h expected 8/1/1/02",
                               db_estado, mem_we, mem_addr, mem_dado);
        end
        cyc();
`endif
        cyc();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
        nota_feita = 1'b0;
        nota       = 4'd0;
        cyc();
`ifdef GRAVA_PAUSA_EN
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd2 || mem_dado !== 8'h72) begin
            errors++; $display("FAIL pausa_w2: got we=%b addr=%0d dado=%0h expected 1/2/72", mem_we, mem_addr, mem_dado);
        end
`else
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd1 || mem_dado !== 8'h72) begin
            errors++; $display("FAIL sem_pausa_w1: got we=%b addr=%0d dado=%0h expected 1/1/72", mem_we, mem_addr, mem_dado);
        end
`endif
        cyc();
    endtask

    task automatic test_cheio();
        restart();
        checks++;
        if (p_db_estado !== 4'd2 || p_num_notas !== 3'd0) begin
            errors++; $display("FAIL cheio_inicio: got estado=%0d num=%0d expected 2/0", p_db_estado, p_num_notas);
        end
        for (int i = 1; i <= 3; i++) begin
            press(4'(i), 0);
            cyc();
        end
        press(4'd4, 0);
        checks++;
        if (p_mem_we !== 1'b1 || p_mem_addr !== 2'd3 || p_mem_dado !== 8'h41) begin
            errors++; $display("FAIL cheio_w3: got we=%b addr=%0d dado=%0h expected 1/3/41", p_mem_we, p_mem_addr, p_mem_dado);
        end
        cyc();
        checks++;
        if (p_db_estado !== 4'd7 || p_memoria_cheia !== 1'b1 || p_fim_gravacao !== 1'b1 || p_gravando !== 1'b0) begin
            errors++; $display("FAIL cheio_estado: got estado=%0d cheia=%b fim=%b grav=%b expected 7/1/1/0",
                               p_db_estado, p_memoria_cheia, p_fim_gravacao, p_gravando);
        end
        checks++;
        if (p_mem_addr !== 2'd3 || p_num_notas !== 3'd4) begin
            errors++; $display("FAIL cheio_contagem: got addr=%0d num=%0d expected 3/4", p_mem_addr, p_num_notas);
        end
        checks++;
        if (db_estado !== 4'd2 || mem_addr !== 6'd4 || num_notas !== 7'd4) begin
            errors++; $display("FAIL grande_sem_cheio: got estado=%0d addr=%0d num=%0d expected 2/4/4", db_estado, mem_addr, num_notas);
        end
        nota_feita = 1'b1;
        nota       = 4'd5;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (p_mem_we !== 1'b0 || p_db_estado !== 4'd7) begin
                errors++; $display("FAIL cheio_tecla: cycle %0d got we=%b estado=%0d expected 0/7", i, p_mem_we, p_db_estado);
            end
        end
        nota_feita = 1'b0;
        nota       = 4'd0;
        cyc();
        cyc();
        checks++;
        if (p_num_notas !== 3'd4 || p_mem_addr !== 2'd3) begin
            errors++; $display("FAIL cheio_hold: got num=%0d addr=%0d expected 4/3", p_num_notas, p_mem_addr);
        end
    endtask

    task automatic test_reset_meio();
        restart();
        nota_feita = 1'b1;
        nota       = 4'd6;
        cyc();
        cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++;
        if (db_estado !== 4'd4) begin errors++; $display("FAIL reset_meio_mede: got estado=%0d expected 4", db_estado); end
        reset = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd0 || mem_we !== 1'b0 || toca !== 1'b0 || mem_dado !== 8'h00) begin
            errors++; $display("FAIL reset_meio: got estado=%0d we=%b toca=%b dado=%0h expected 0/0/0/0",
                               db_estado, mem_we, toca, mem_dado);
        end
        nota_feita = 1'b0;
        nota       = 4'd0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (mem_we !== 1'b0 || p_mem_we !== 1'b0 || num_notas !== 7'd0 || mem_addr !== 6'd0) begin
                errors++; $display("FAIL reset_meio_sem_escrita: got we=%b pwe=%b num=%0d addr=%0d expected 0/0/0/0",
                                   mem_we, p_mem_we, num_notas, mem_addr);
            end
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_meio_inicial: got estado=%0d expected 0", db_estado); end
    endtask

    task automatic test_finalizar_tecla();
        iniciar = 1'b1;
        cyc();
        iniciar = 1'b0;
        cyc();
        nota_feita = 1'b1;
        nota       = 4'd2;
        cyc();
        cyc();
        finalizar = 1'b1;
        nota      = 4'd9;
        tick      = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        checks++;
        if (db_estado !== 4'd4) begin errors++; $display("FAIL finalizar_ignorado: got estado=%0d expected 4", db_estado); end
        nota_feita = 1'b0;
        nota       = 4'd0;
        cyc();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_dado !== 8'h22) begin
            errors++; $display("FAIL finalizar_grava: got we=%b addr=%0d dado=%0h expected 1/0/22", mem_we, mem_addr, mem_dado);
        end
        cyc();
        cyc();
        checks++;
        if (db_estado !== 4'd6 || fim_gravacao !== 1'b1 || num_notas !== 7'd1 || mem_addr !== 6'd1) begin
            errors++; $display("FAIL finalizar_fim: got estado=%0d fim=%b num=%0d addr=%0d expected 6/1/1/1",
                               db_estado, fim_gravacao, num_notas, mem_addr);
        end
        finalizar = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_nota();
        test_saturacao();
        test_pausa();
        test_cheio();
        test_reset_meio();
        test_finalizar_tecla();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
